// File: rtl/guess_pkg.sv
// Shared types for the guess-number game stages.
// Digit/answer types, digit limits and the secret_gen state encoding.
package guess_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0]  bcd_t;
    typedef logic [15:0] ans_t;

    localparam bcd_t DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        SG_IDLE = 2'd0,
        SG_DRAW = 2'd1,
        SG_DONE = 2'd2
    } sg_state_e;

    // One-hot of a digit in used-bitmap form; 10..15 map to zero.
    function automatic logic [9:0] digit_onehot(bcd_t d);
        logic [15:0] oh;
        oh = 16'b1 << d;
        return oh[9:0];
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with an entropy bit on the feedback.
// An all-zero next value is replaced by the seed so it never locks up.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        entropy,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [15:0] step;

    // Next LFSR value: shift, tap feedback, entropy mix, lockup guard
    always_comb begin
        step = {1'b0, lfsr_q[15:1]}
             ^ (lfsr_q[0] ? TAPS : 16'h0000)
             ^ {15'b0, entropy};
        lfsr_d = (step == 16'h0000) ? SEED : step;
    end

    // LFSR register, stepping every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/secret_gen.sv
// Draws a 4-digit secret of distinct BCD digits by rejection sampling.
// Define SECRET_GEN_NO_LEAD_ZERO_EN to forbid 0 as the leading digit.
module secret_gen
    import guess_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [15:0] LFSR_TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        entropy,
    output logic        busy,
    output logic        ans_valid,
    output logic [15:0] ans
);

    logic [15:0] lfsr;
    bcd_t        cand;
    logic [9:0]  cand_oh;
    logic        lead_block;
    logic        accept;

    sg_state_e   state_q, state_d;
    logic [9:0]  used_q, used_d;
    logic [1:0]  slot_q, slot_d;
    ans_t        ans_q, ans_d;
    logic        ans_valid_q, ans_valid_d;

    lfsr16 #(
        .SEED (LFSR_SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .entropy (entropy),
        .lfsr    (lfsr)
    );

    // Candidate digit and accept decision for this cycle
    always_comb begin
        cand    = lfsr[3:0];
        cand_oh = digit_onehot(cand);
`ifdef SECRET_GEN_NO_LEAD_ZERO_EN
        lead_block = (slot_q == 2'd0) && (cand == 4'd0);
`else
        lead_block = 1'b0;
`endif
        accept = (cand <= DIGIT_MAX)
              && ((cand_oh & used_q) == 10'b0)
              && !lead_block;
    end

    // Draw FSM: fill slots on accept, flag the answer one cycle after
    always_comb begin
        state_d     = state_q;
        used_d      = used_q;
        slot_d      = slot_q;
        ans_d       = ans_q;
        ans_valid_d = ans_valid_q;
        unique case (state_q)
            SG_IDLE: begin
                if (start) begin
                    state_d     = SG_DRAW;
                    used_d      = 10'b0;
                    slot_d      = 2'd0;
                    ans_valid_d = 1'b0;
                end
            end
            SG_DRAW: begin
                if (accept) begin
                    used_d = used_q | cand_oh;
                    slot_d = slot_q + 2'd1;
                    unique case (slot_q)
                        2'd0: ans_d[15:12] = cand;
                        2'd1: ans_d[11:8]  = cand;
                        2'd2: ans_d[7:4]   = cand;
                        2'd3: ans_d[3:0]   = cand;
                    endcase
                    if (slot_q == 2'(NUM_DIGITS - 1)) begin
                        state_d = SG_DONE;
                    end
                end
            end
            SG_DONE: begin
                ans_valid_d = 1'b1;
                state_d     = SG_IDLE;
            end
            default: begin
                state_d = SG_IDLE;
            end
        endcase
    end

    // FSM and answer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SG_IDLE;
            used_q      <= 10'b0;
            slot_q      <= 2'd0;
            ans_q       <= 16'h0000;
            ans_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            used_q      <= used_d;
            slot_q      <= slot_d;
            ans_q       <= ans_d;
            ans_valid_q <= ans_valid_d;
        end
    end

    assign busy      = (state_q != SG_IDLE);
    assign ans_valid = ans_valid_q;
    assign ans       = ans_q;

endmodule

// File: tb/tb_secret_gen.sv
// Directed bench for secret_gen with a cycle model of the draw.
// A second instance seeded 16'h0002 exercises the LFSR lockup guard.
module tb_secret_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, entropy;
    logic        busy, ans_valid;
    logic [15:0] ans;
    logic        start_z, entropy_z;
    logic        busy_z, ans_valid_z;
    logic [15:0] ans_z;

    int total = 0;
    int bad   = 0;
    int cyc;

`ifdef SECRET_GEN_NO_LEAD_ZERO_EN
    localparam bit NO_LZ = 1'b1;
`else
    localparam bit NO_LZ = 1'b0;
`endif

    always #5 clk = ~clk;

    secret_gen #(
        .LFSR_SEED (16'hACE1),
        .LFSR_TAPS (16'hB400)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .entropy   (entropy),
        .busy      (busy),
        .ans_valid (ans_valid),
        .ans       (ans)
    );

    secret_gen #(
        .LFSR_SEED (16'h0002),
        .LFSR_TAPS (16'hB400)
    ) dut_z (
        .clk       (clk),
        .reset     (reset),
        .start     (start_z),
        .entropy   (entropy_z),
        .busy      (busy_z),
        .ans_valid (ans_valid_z),
        .ans       (ans_z)
    );

    // Reference model of the draw for the main instance
    logic [15:0] m_lfsr;
    logic [1:0]  m_st;
    logic [9:0]  m_used;
    logic [1:0]  m_slot;
    logic [15:0] m_ans;
    logic        m_valid;
    logic        m_busy;

    assign m_busy = (m_st != 2'd0);

    function automatic logic [15:0] f_step(logic [15:0] l, logic e);
        logic [15:0] n;
        n = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000) ^ {15'b0, e};
        if (n == 16'h0000) n = 16'hACE1;
        return n;
    endfunction

    function automatic bit m_accept(logic [15:0] l, logic [9:0] u,
                                    logic [1:0] s);
        int c;
        c = int'(l[3:0]);
        if (c > 9) return 1'b0;
        if (u[c]) return 1'b0;
        if (NO_LZ && s == 2'd0 && c == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit ok_secret(logic [15:0] a);
        logic [9:0] m;
        logic [3:0] d;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            d = a[i*4 +: 4];
            if (d > 4'd9) return 1'b0;
            if (m[d]) return 1'b0;
            m[d] = 1'b1;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lfsr  <= 16'hACE1;
            m_st    <= 2'd0;
            m_used  <= '0;
            m_slot  <= '0;
            m_ans   <= '0;
            m_valid <= 1'b0;
            cyc     <= 0;
        end else begin
            cyc    <= cyc + 1;
            m_lfsr <= f_step(m_lfsr, entropy);
            case (m_st)
                2'd0: if (start) begin
                    m_st    <= 2'd1;
                    m_used  <= '0;
                    m_slot  <= '0;
                    m_valid <= 1'b0;
                end
                2'd1: if (m_accept(m_lfsr, m_used, m_slot)) begin
                    m_ans[(3 - int'(m_slot))*4 +: 4] <= m_lfsr[3:0];
                    m_used[m_lfsr[3:0]] <= 1'b1;
                    m_slot <= m_slot + 2'd1;
                    if (m_slot == 2'd3) m_st <= 2'd2;
                end
                default: begin
                    m_valid <= 1'b1;
                    m_st    <= 2'd0;
                end
            endcase
        end
    end

    task automatic test_reset;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        total++;
        if (ans_valid !== 1'b0) begin
            bad++; $display("FAIL rst_valid: got %b want 0", ans_valid);
        end
        total++;
        if (ans !== 16'h0000) begin
            bad++; $display("FAIL rst_ans: got %h want 0000", ans);
        end
        total++;
        if (dut.u_lfsr.lfsr_q !== 16'hACE1) begin
            bad++;
            $display("FAIL rst_lfsr: got %h want ace1", dut.u_lfsr.lfsr_q);
        end
    endtask

    task automatic test_first_draw;
        logic [15:0] exp_l [4];
        bit done;
        exp_l = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E};
        entropy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++;
            if (dut.u_lfsr.lfsr_q !== exp_l[i]) begin
                bad++;
                $display("FAIL lfsr_step%0d: got %h want %h",
                         i, dut.u_lfsr.lfsr_q, exp_l[i]);
            end
        end
        while (cyc < 9) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL first_busy: got %b want 1", busy);
        end
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk); #1;
            total++;
            if ({busy, ans_valid} !== {m_busy, m_valid}) begin
                bad++;
                $display("FAIL first_flags: got %b%b want %b%b",
                         busy, ans_valid, m_busy, m_valid);
            end
            done = ans_valid;
        end
        total++;
        if (!done) begin
            bad++; $display("FAIL first_timeout: got no valid want valid");
        end
        total++;
        if (cyc != 17) begin
            bad++; $display("FAIL first_rise: got cyc %0d want 17", cyc);
        end
        total++;
        if (ans !== 16'h1865) begin
            bad++; $display("FAIL first_ans: got %h want 1865", ans);
        end
    endtask

    task automatic test_start_spam;
        int  rises;
        bit  prev, fin;
        entropy = 1'b0;
        for (int d = 0; d < 3; d++) begin
            rises = 0;
            prev  = ans_valid;
            fin   = 1'b0;
            start = 1'b1;
            for (int n = 0; n < 300 && !fin; n++) begin
                @(posedge clk); #1;
                if (ans_valid && !prev) rises++;
                prev = ans_valid;
                if (!busy && ans_valid) begin
                    start = 1'b0;
                    fin   = 1'b1;
                end
            end
            start = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                if (ans_valid && !prev) rises++;
                prev = ans_valid;
            end
            total++;
            if (rises != 1) begin
                bad++; $display("FAIL spam_rises%0d: got %0d want 1", d, rises);
            end
            total++;
            if (ans !== m_ans || !ok_secret(ans)) begin
                bad++; $display("FAIL spam_ans%0d: got %h want %h", d, ans, m_ans);
            end
        end
    endtask

    task automatic test_coincident;
        bit done;
        entropy = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk); #1;
            done = ans_valid;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if ({ans_valid, busy} !== 2'b01) begin
            bad++;
            $display("FAIL coin_drop: got v%b b%b want v0 b1", ans_valid, busy);
        end
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk); #1;
            done = ans_valid;
        end
        total++;
        if (!done || ans !== m_ans || !ok_secret(ans)) begin
            bad++;
            $display("FAIL coin_ans: got %h v%b want %h v1", ans, done, m_ans);
        end
    endtask

    task automatic test_reset_mid_draw;
        bit hit, done;
        entropy = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 300 && !hit; n++) begin
            @(posedge clk); #1;
            hit = (m_st == 2'd1 && m_slot == 2'd2);
        end
        total++;
        if (!hit) begin
            bad++; $display("FAIL mid_reach: got no slot2 want slot2");
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({busy, ans_valid, ans} !== 18'h0) begin
            bad++;
            $display("FAIL mid_rst: got b%b v%b %h want b0 v0 0000",
                     busy, ans_valid, ans);
        end
        total++;
        if (dut.u_lfsr.lfsr_q !== 16'hACE1) begin
            bad++;
            $display("FAIL mid_lfsr: got %h want ace1", dut.u_lfsr.lfsr_q);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if ({busy, ans_valid, ans} !== 18'h0) begin
            bad++;
            $display("FAIL mid_hold: got b%b v%b %h want b0 v0 0000",
                     busy, ans_valid, ans);
        end
        while (cyc < 9) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk); #1;
            done = ans_valid;
        end
        total++;
        if (!done || cyc != 17 || ans !== 16'h1865) begin
            bad++;
            $display("FAIL mid_redraw: got %h cyc %0d want 1865 cyc 17",
                     ans, cyc);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] seen [4];
        logic [9:0] want;
        bit done;
        int errs;
        errs = 0;
        for (int s = 0; s < 4; s++) seen[s] = '0;
        for (int d = 0; d < 1000; d++) begin
            entropy = 1'($urandom_range(0, 1));
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            done = 1'b0;
            for (int n = 0; n < 500 && !done; n++) begin
                entropy = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                done = ans_valid;
            end
            total++;
            if (!done || ans !== m_ans || !ok_secret(ans)) begin
                bad++;
                if (errs < 5)
                    $display("FAIL b2b_ans%0d: got %h v%b want %h v1",
                             d, ans, done, m_ans);
                errs++;
            end
            for (int s = 0; s < 4; s++) begin
                if (ans[(3-s)*4 +: 4] <= 4'd9)
                    seen[s][ans[(3-s)*4 +: 4]] = 1'b1;
            end
        end
        entropy = 1'b0;
        for (int s = 0; s < 4; s++) begin
            want = (NO_LZ && s == 0) ? 10'h3FE : 10'h3FF;
            total++;
            if (seen[s] !== want) begin
                bad++;
                $display("FAIL b2b_cov%0d: got %b want %b", s, seen[s], want);
            end
        end
    endtask

    task automatic test_lockup;
        bit done;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if (dut_z.u_lfsr.lfsr_q !== 16'h0002) begin
            bad++;
            $display("FAIL lock_seed: got %h want 0002", dut_z.u_lfsr.lfsr_q);
        end
        entropy_z = 1'b1;
        @(posedge clk); #1;
        total++;
        if (dut_z.u_lfsr.lfsr_q !== 16'h0002) begin
            bad++;
            $display("FAIL lock_guard: got %h want 0002", dut_z.u_lfsr.lfsr_q);
        end
        entropy_z = 1'b0;
        @(posedge clk); #1;
        total++;
        if (dut_z.u_lfsr.lfsr_q !== 16'h0001) begin
            bad++;
            $display("FAIL lock_next: got %h want 0001", dut_z.u_lfsr.lfsr_q);
        end
        start_z = 1'b1;
        @(posedge clk); #1;
        start_z = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 500 && !done; n++) begin
            @(posedge clk); #1;
            done = ans_valid_z;
        end
        total++;
        if (!done || !ok_secret(ans_z)) begin
            bad++;
            $display("FAIL lock_draw: got %h v%b want distinct bcd v1",
                     ans_z, done);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        entropy   = 1'b0;
        start_z   = 1'b0;
        entropy_z = 1'b0;
        repeat (2) @(posedge clk);
        test_reset;
        test_first_draw;
        test_start_spam;
        test_coincident;
        test_reset_mid_draw;
        test_back_to_back;
        test_lockup;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/secret_gen.md
Name: secret_gen

Overview:
- Upstream stage of the guess-number game. Produces the 4-digit secret answer that the guess/compare stage loads into its answer registers.
- The secret is 4 distinct decimal digits, drawn from a free-running LFSR by rejection sampling and tracked with a 10-bit used-digit bitmap.
- The game controller pulses start on game reset or on a win. The answer is presented with a level-valid until the next draw.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- LFSR_TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11, maximal length).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request for a new secret
- entropy  in  1  raw bit (e.g. button-timing counter LSB) XORed into LFSR feedback
- busy  out  1  high while a draw is in progress
- ans_valid  out  1  high while ans holds a completed secret
- ans  out  16  {a7,a6,a5,a4}, 4 BCD digits, a7 = most significant

Behaviour:
- Reset values: lfsr = LFSR_SEED; state = IDLE; used = 10'b0; slot = 0; ans = 16'h0000; busy = 0; ans_valid = 0.
- LFSR step, every cycle in every state:
  - lsb = lfsr[0]; lfsr <= (lfsr >> 1) ^ (lsb ? LFSR_TAPS : 0) ^ {15'b0, entropy}.
  - If the result would be all-zero, load LFSR_SEED instead (lockup guard).
- The candidate digit each cycle is cand = lfsr[3:0].
- FSM states: IDLE, DRAW, DONE.
  - IDLE: on start = 1, go to DRAW. Clear used, slot = 0, ans_valid = 0; ans is retained until overwritten.
  - DRAW: each cycle the candidate is accepted iff cand <= 9 and used[cand] == 0.
    - On accept: write cand to digit slot (slot 0 -> a7 … slot 3 -> a4), set used[cand], slot++.
    - On reject: no change.
    - The accept that fills slot 3 moves the FSM to DONE.
  - DONE: one cycle. ans_valid <= 1, then return to IDLE.
- busy = 1 in DRAW and DONE; 0 in IDLE.
- Latency:
  - Minimum 5 cycles from the start-sampled edge to ans_valid rising (4 accepts + DONE).
  - No upper bound is guaranteed architecturally. Maximal-length LFSR coverage makes every digit reachable, so completion is certain.
- start while busy = 1 is ignored; no queuing.
- start in the same cycle ans_valid rises: sampled next cycle in IDLE; a new draw begins and ans_valid drops.
- ans digits change only in DRAW. Digits not yet redrawn keep their old values, but ans_valid = 0 during that time.
- Reset mid-DRAW: immediate return to reset values; the partial secret is discarded.
- Invariant whenever ans_valid = 1: all four digits are <= 9 and pairwise distinct.

Optional Feature:
- Macro: SECRET_GEN_NO_LEAD_ZERO_EN.
- Defined: in slot 0, cand == 0 is also rejected, so a7 ∈ 1..9. Slots 1..3 are unchanged.
- Undefined: a7 may be 0.
- Used-bitmap behaviour is otherwise identical.

Decomposition:
- Shared package guess_pkg:
  - BCD digit typedef (4 bits) and 16-bit answer typedef.
  - NUM_DIGITS = 4 and DIGIT_MAX = 9.
  - FSM state enum for secret_gen.
  - These are reused by the compare stage.
- One sub-module: lfsr16 (seed/taps parameters, entropy input, lockup guard, free-running).
- Accept logic and FSM stay in secret_gen.

Test Plan:
- Reset, hold entropy = 0, pulse start at cycle 10 -> busy rises at 11. The ans_valid rise cycle and digits match a bench LFSR model seeded 16'hACE1 (first LFSR steps E270, 7138, 389C, 1C4E). ans_valid at >= cycle 15; digits <= 9 and distinct.
- 1000 back-to-back draws with random entropy -> every ans has 4 distinct BCD digits. Every digit 0..9 appears in every slot (with the macro, 1..9 only in a7 and no a7 = 0).
- start pulsed on every cycle of a draw -> exactly one ans_valid rise per draw. Digits are unaffected by extra pulses.
- reset asserted mid-DRAW after 2 accepts -> next cycle busy = 0, ans_valid = 0, ans = 16'h0000. A subsequent start redraws from LFSR_SEED and matches the model.
- start coincident with the ans_valid rise -> ans_valid high for exactly 1 cycle, then a new draw and new valid secret.
- Force the all-zero LFSR via entropy/seed corner (bench-driven) -> next cycle lfsr = LFSR_SEED, draw completes.
